// File: rtl/ni_sync_master.sv
// ----------------------------------------------------------------------------
// ni_sync_master
//   Initiator side of the NI mode-sync protocol. Emits a one-cycle strobe
//   (clk_div_8_to_NI) every DIV enabled clock cycles and keeps a reference
//   copy of the mode the NI mode register should hold. One cycle after each
//   strobe (the "check cycle") the mode fed back from the NI is compared with
//   the reference. The block reports lock, a one-cycle mismatch pulse and a
//   saturating mismatch count.
//
// Ports
//   clk             in   main clock, all logic on the rising edge
//   reset_n         in   asynchronous active-low reset
//   enable          in   run strobe generation and checking
//   resync          in   restart the strobe period and lock acquisition
//   clk_div_8_to_NI out  registered strobe, high one cycle every DIV cycles
//   mode_ref        out  expected NI mode, toggles after every strobe
//   mode_fb         in   mode returned by the NI mode register
//   locked          out  LOCK_CYCLES consecutive matching checks seen
//   mismatch        out  one-cycle pulse, a check failed
//   mismatch_count  out  failed checks since reset, saturates at all-ones
//   fsm_state       out  debug view of the lock FSM (0 IDLE, 1 ACQUIRE, 2 LOCKED)
// ----------------------------------------------------------------------------
module ni_sync_master #(
  parameter int DIV         = 8,
  parameter int CNT_W       = 3,
  parameter int LOCK_CYCLES = 4,
  parameter int MISMATCH_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  resync,
  output logic                  clk_div_8_to_NI,
  output logic                  mode_ref,
  input  logic                  mode_fb,
  output logic                  locked,
  output logic                  mismatch,
  output logic [MISMATCH_W-1:0] mismatch_count,
  output logic [1:0]            fsm_state
);

  localparam int MC_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  strobe_q, strobe_d;
  logic                  strobe_dly_q, strobe_dly_d;
  logic                  mode_ref_q, mode_ref_d;
  logic                  locked_q, locked_d;
  logic                  mismatch_q, mismatch_d;
  logic [MISMATCH_W-1:0] mm_cnt_q, mm_cnt_d;
  logic [MC_W-1:0]       match_cnt_q, match_cnt_d;
  logic                  check_fail;

  // Datapath: period counter, strobe, reference mode and check bookkeeping.
  always_comb begin
    cnt_d        = cnt_q;
    strobe_d     = strobe_q;
    strobe_dly_d = strobe_dly_q;
    mode_ref_d   = mode_ref_q;
    mismatch_d   = 1'b0;
    mm_cnt_d     = mm_cnt_q;
    match_cnt_d  = match_cnt_q;
    check_fail   = 1'b0;

    if (!enable || resync) begin
      // Disabled, or restarting: drop the period and lock progress but keep
      // the reference mode and the mismatch history. A check that would
      // have happened this cycle is skipped.
      cnt_d        = '0;
      strobe_d     = 1'b0;
      strobe_dly_d = 1'b0;
      match_cnt_d  = '0;
    end else begin
      if (cnt_q == CNT_W'(DIV - 1)) begin
        cnt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        cnt_d    = cnt_q + CNT_W'(1);
        strobe_d = 1'b0;
      end
      strobe_dly_d = strobe_q;

      // The NI toggles on the same edge that sees the strobe high.
      if (strobe_q) begin
        mode_ref_d = ~mode_ref_q;
      end

      // Check cycle. strobe_q and strobe_dly_q are never high together
      // (DIV >= 2), so the toggle above and this compare do not collide.
      if (strobe_dly_q) begin
        if (mode_fb != mode_ref_q) begin
          check_fail  = 1'b1;
          mismatch_d  = 1'b1;
          match_cnt_d = '0;
          mode_ref_d  = mode_fb;  // adopt the NI phase
          if (mm_cnt_q != '1) begin
            mm_cnt_d = mm_cnt_q + MISMATCH_W'(1);
          end
        end else if (match_cnt_q != MC_W'(LOCK_CYCLES)) begin
          match_cnt_d = match_cnt_q + MC_W'(1);
        end
      end
    end
  end

  // Lock FSM next state.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (resync) begin
      state_d = ACQUIRE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (match_cnt_d == MC_W'(LOCK_CYCLES)) state_d = LOCKED;
        LOCKED:  if (check_fail) state_d = ACQUIRE;
        default: state_d = IDLE;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      strobe_q     <= 1'b0;
      strobe_dly_q <= 1'b0;
      mode_ref_q   <= 1'b0;
      locked_q     <= 1'b0;
      mismatch_q   <= 1'b0;
      mm_cnt_q     <= '0;
      match_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      strobe_q     <= strobe_d;
      strobe_dly_q <= strobe_dly_d;
      mode_ref_q   <= mode_ref_d;
      locked_q     <= locked_d;
      mismatch_q   <= mismatch_d;
      mm_cnt_q     <= mm_cnt_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign clk_div_8_to_NI = strobe_q;
  assign mode_ref        = mode_ref_q;
  assign locked          = locked_q;
  assign mismatch        = mismatch_q;
  assign mismatch_count  = mm_cnt_q;
  assign fsm_state       = state_q;

endmodule
